// File: rtl/dmem_dma_if.sv
// dmem_dma_if: command handshake, CPU-side port and memory-side port of the data-memory DMA engine
// master: engine view (takes command/CPU request/read data, drives memory port/status)
// slave : environment view (drives command/CPU request/read data, observes memory port/status)
interface dmem_dma_if;
  logic start;
  logic [1:0] op;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic [15:0] fill_val;
  logic abort;
  logic cpu_we;
  logic [7:0] cpu_addr;
  logic [15:0] cpu_dataout;
  logic [15:0] cpu_datain;
  logic d_we;
  logic [7:0] d_addr;
  logic [15:0] d_dataout;
  logic [15:0] d_datain;
  logic busy;
  logic done;
  logic [15:0] result;
  modport master (
    input start, op, src, dst, len, fill_val, abort, cpu_we, cpu_addr, cpu_dataout, d_datain,
    output cpu_datain, d_we, d_addr, d_dataout, busy, done, result
  );
  modport slave (
    output start, op, src, dst, len, fill_val, abort, cpu_we, cpu_addr, cpu_dataout, d_datain,
    input cpu_datain, d_we, d_addr, d_dataout, busy, done, result
  );
endinterface

// File: rtl/dmem_dma_engine.sv
// dmem_dma_engine: copy/fill/checksum bus master on the 8-bit-address, 16-bit data memory port
// mem_clk/reset: clock and synchronous active-high reset
// bus (master): start/op/src/dst/len/fill_val/abort command, busy/done/result status,
//               cpu_* pass-through request, d_* memory port
module dmem_dma_engine (
  input logic mem_clk,
  input logic reset,
  dmem_dma_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [1:0] OP_COPY = 2'b00, OP_FILL = 2'b01, OP_SUM = 2'b10, OP_NOP = 2'b11;
  state_t state, nxt;
  logic [1:0] op_r;
  logic [7:0] sp, dp, rem;
  logic [15:0] fv, buf_r, acc, res_r;
  logic last, busy_i;
  assign last = rem == 8'd1;
  assign busy_i = state == READ || state == WRITE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.start) nxt = (bus.len == 8'd0 || bus.op == OP_NOP) ? DONE : bus.op == OP_FILL ? WRITE : READ;
      READ: nxt = bus.abort ? IDLE : op_r == OP_COPY ? WRITE : last ? DONE : READ;
      WRITE: nxt = bus.abort ? IDLE : last ? DONE : op_r == OP_FILL ? WRITE : READ;
      DONE: nxt = IDLE;
    endcase
  end
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state <= IDLE;
      op_r <= OP_NOP;
      sp <= '0;
      dp <= '0;
      rem <= '0;
      fv <= '0;
      buf_r <= '0;
      acc <= '0;
      res_r <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (bus.start) begin
          op_r <= bus.op;
          sp <= bus.src;
          dp <= bus.dst;
          rem <= bus.len;
          fv <= bus.fill_val;
          acc <= '0;
        end
        READ: begin
          sp <= sp + 8'd1;
          buf_r <= bus.d_datain;
          if (op_r == OP_SUM) begin
            acc <= acc + bus.d_datain;
            rem <= rem - 8'd1;
          end
        end
        WRITE: begin
          dp <= dp + 8'd1;
          rem <= rem - 8'd1;
        end
        DONE: if (op_r == OP_SUM) res_r <= acc;
      endcase
    end
  end
  assign bus.busy = busy_i;
  assign bus.done = state == DONE;
  // reset gates the write strobe combinationally so a command cut by reset never lands a partial write
  assign bus.d_we = !reset && (state == WRITE || (!busy_i && bus.cpu_we));
  assign bus.d_addr = state == READ ? sp : state == WRITE ? dp : bus.cpu_addr;
  assign bus.d_dataout = state == WRITE ? (op_r == OP_FILL ? fv : buf_r) : bus.cpu_dataout;
  assign bus.cpu_datain = bus.d_datain;
  // the finished checksum is visible already in the DONE cycle, then held in res_r
  assign bus.result = (state == DONE && op_r == OP_SUM) ? acc : res_r;
endmodule

// File: tb/tb_dmem_dma_engine.sv
// tb_dmem_dma_engine: directed self-checking bench for dmem_dma_engine with a behavioural data memory
module tb_dmem_dma_engine;
  logic mem_clk = 1'b0;
  logic reset = 1'b1;
  always #5 mem_clk = ~mem_clk;
  dmem_dma_if bus ();
  dmem_dma_engine dut (.mem_clk(mem_clk), .reset(reset), .bus(bus));
  logic [15:0] mem [256];
  always @(posedge mem_clk) if (bus.d_we) mem[bus.d_addr] <= bus.d_dataout;
  assign bus.d_datain = mem[bus.d_addr];
  int tests = 0;
  int fails = 0;
  int busy_cnt, done_cyc, we_cnt, we_odd;
  logic [7:0] wa [16];

  task automatic launch(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                        input logic [7:0] len, input logic [15:0] fv);
    @(negedge mem_clk);
    bus.op = op; bus.src = src; bus.dst = dst; bus.len = len; bus.fill_val = fv; bus.start = 1'b1;
    @(posedge mem_clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_obs();
    busy_cnt = 0; done_cyc = -1; we_cnt = 0; we_odd = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge mem_clk);
      if (bus.busy) busy_cnt++;
      if (bus.d_we) begin
        if (we_cnt < 16) wa[we_cnt] = bus.d_addr;
        we_cnt++;
        if (c % 2 == 1) we_odd++;
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    @(posedge mem_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h99; bus.cpu_dataout = 16'hdead;
    repeat (2) @(posedge mem_clk);
    @(negedge mem_clk);
    tests++; if (bus.d_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", bus.d_we); end
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL reset_status busy=%b done=%b want 0 0", bus.busy, bus.done); end
    tests++; if (bus.result !== 16'h0000) begin fails++; $display("FAIL reset_result got %h want 0000", bus.result); end
    bus.cpu_we = 1'b0;
    reset = 1'b0;
    @(negedge mem_clk);
    tests++; if (mem[8'h99] !== 16'h0000) begin fails++; $display("FAIL reset_nowrite got %h want 0000", mem[8'h99]); end
  endtask

  task automatic test_passthrough();
    @(negedge mem_clk);
    bus.cpu_we = 1'b1; bus.cpu_addr = 8'h20; bus.cpu_dataout = 16'h1234;
    @(posedge mem_clk);
    #1 bus.cpu_we = 1'b0;
    @(negedge mem_clk);
    tests++; if (mem[8'h20] !== 16'h1234) begin fails++; $display("FAIL pass_write got %h want 1234", mem[8'h20]); end
    tests++; if (bus.cpu_datain !== 16'h1234) begin fails++; $display("FAIL pass_read got %h want 1234", bus.cpu_datain); end
  endtask

  task automatic test_checksum();
    launch(2'b10, 8'h00, 8'h00, 8'd8, 16'h0000);
    run_obs();
    tests++; if (busy_cnt != 8) begin fails++; $display("FAIL sum_busy got %0d want 8", busy_cnt); end
    tests++; if (done_cyc != 9) begin fails++; $display("FAIL sum_done got %0d want 9", done_cyc); end
    tests++; if (bus.result !== 16'h2d73) begin fails++; $display("FAIL sum_result got %h want 2d73", bus.result); end
    tests++; if (we_cnt != 0) begin fails++; $display("FAIL sum_nowrite got %0d want 0", we_cnt); end
  endtask

  task automatic test_copy();
    launch(2'b00, 8'h00, 8'h10, 8'd4, 16'h0000);
    run_obs();
    tests++; if (done_cyc != 9 || busy_cnt != 8) begin fails++; $display("FAIL copy_timing done=%0d busy=%0d want 9 8", done_cyc, busy_cnt); end
    tests++; if (we_cnt != 4 || we_odd != 0) begin fails++; $display("FAIL copy_we writes=%0d odd=%0d want 4 0", we_cnt, we_odd); end
    tests++; if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 64'hfffd_0004_0005_c369) begin
      fails++; $display("FAIL copy_data got %h %h %h %h want fffd 0004 0005 c369", mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
    tests++; if (bus.result !== 16'h2d73) begin fails++; $display("FAIL copy_result_kept got %h want 2d73", bus.result); end
  endtask

  task automatic test_overlap();
    launch(2'b00, 8'h00, 8'h01, 8'd3, 16'h0000);
    run_obs();
    tests++; if ({mem[8'h01], mem[8'h02], mem[8'h03]} !== 48'hfffd_fffd_fffd) begin
      fails++; $display("FAIL overlap_data got %h %h %h want fffd fffd fffd", mem[8'h01], mem[8'h02], mem[8'h03]);
    end
    tests++; if (done_cyc != 7) begin fails++; $display("FAIL overlap_done got %0d want 7", done_cyc); end
  endtask

  task automatic test_len0();
    launch(2'b00, 8'h00, 8'h30, 8'd0, 16'h0000);
    run_obs();
    tests++; if (done_cyc != 1) begin fails++; $display("FAIL len0_done got %0d want 1", done_cyc); end
    tests++; if (busy_cnt != 0 || we_cnt != 0) begin fails++; $display("FAIL len0_idle busy=%0d writes=%0d want 0 0", busy_cnt, we_cnt); end
  endtask

  task automatic test_fill_wrap();
    launch(2'b01, 8'h00, 8'hfe, 8'd4, 16'ha5a5);
    run_obs();
    tests++; if (done_cyc != 5 || busy_cnt != 4) begin fails++; $display("FAIL fill_timing done=%0d busy=%0d want 5 4", done_cyc, busy_cnt); end
    tests++; if (we_cnt != 4 || {wa[0], wa[1], wa[2], wa[3]} !== 32'hfeff_0001) begin
      fails++; $display("FAIL fill_order writes=%0d addrs=%h %h %h %h want 4 fe ff 00 01", we_cnt, wa[0], wa[1], wa[2], wa[3]);
    end
    tests++; if (mem[8'h00] !== 16'ha5a5 || mem[8'hff] !== 16'ha5a5) begin fails++; $display("FAIL fill_data got %h %h want a5a5 a5a5", mem[8'h00], mem[8'hff]); end
  endtask

  task automatic test_abort();
    int w = 0;
    int d = 0;
    launch(2'b01, 8'h00, 8'h40, 8'd10, 16'h0bad);
    for (int k = 1; k <= 3; k++) begin
      @(negedge mem_clk);
      if (bus.d_we) w++;
      if (k == 3) bus.abort = 1'b1;
    end
    @(posedge mem_clk);
    #1 bus.abort = 1'b0;
    @(negedge mem_clk);
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL abort_idle busy=%b done=%b want 0 0", bus.busy, bus.done); end
    for (int k = 0; k < 12; k++) begin
      if (bus.d_we) w++;
      if (bus.done) d++;
      @(negedge mem_clk);
    end
    tests++; if (w != 3 || d != 0) begin fails++; $display("FAIL abort_count writes=%0d dones=%0d want 3 0", w, d); end
    tests++; if (mem[8'h42] !== 16'h0bad || mem[8'h43] !== 16'h0000) begin fails++; $display("FAIL abort_data got %h %h want 0bad 0000", mem[8'h42], mem[8'h43]); end
  endtask

  task automatic test_start_ignored();
    int w = 0;
    int d = 0;
    launch(2'b01, 8'h00, 8'h50, 8'd3, 16'h1111);
    @(negedge mem_clk);
    if (bus.d_we) w++;
    bus.op = 2'b00; bus.dst = 8'h60; bus.len = 8'd5; bus.start = 1'b1;
    @(posedge mem_clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge mem_clk);
      if (bus.d_we) w++;
      if (bus.done) d++;
    end
    tests++; if (w != 3 || d != 1) begin fails++; $display("FAIL ignore_start writes=%0d dones=%0d want 3 1", w, d); end
    tests++; if (mem[8'h52] !== 16'h1111 || mem[8'h60] !== 16'h0000) begin fails++; $display("FAIL ignore_data got %h %h want 1111 0000", mem[8'h52], mem[8'h60]); end
  endtask

  task automatic test_reset_mid();
    mem[8'h70] = 16'h7777;
    launch(2'b00, 8'h00, 8'h70, 8'd2, 16'h0000);
    @(negedge mem_clk);
    @(negedge mem_clk);
    reset = 1'b1;
    #1;
    tests++; if (bus.d_we !== 1'b0) begin fails++; $display("FAIL rstmid_we got %b want 0", bus.d_we); end
    @(posedge mem_clk);
    #1 reset = 1'b0;
    @(negedge mem_clk);
    tests++; if (bus.busy !== 1'b0 || bus.result !== 16'h0000) begin fails++; $display("FAIL rstmid_state busy=%b result=%h want 0 0000", bus.busy, bus.result); end
    tests++; if (mem[8'h70] !== 16'h7777) begin fails++; $display("FAIL rstmid_data got %h want 7777", mem[8'h70]); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b11; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
    bus.abort = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_dataout = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'hfffd; mem[1] = 16'h0004; mem[2] = 16'h0005; mem[3] = 16'hc369;
    mem[4] = 16'h69c3; mem[5] = 16'h0041; mem[6] = 16'hffff; mem[7] = 16'h0001;
    test_reset();
    test_passthrough();
    test_checksum();
    test_copy();
    test_overlap();
    test_len0();
    test_fill_wrap();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
